// File: rtl/mem_arbiter_pkg.sv
// Shared bus macros and arbiter types for the memory-port arbiter.
// The bus macros are guarded so a project-wide def.svh may supply them first.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif
`ifndef ZERO_ADDR
`define ZERO_ADDR 32'h0000_0000
`endif
`ifndef ZERO_DATA
`define ZERO_DATA 32'h0000_0000
`endif

package mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational circular scan: first set request at or after start.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Walk offsets from far to near so the nearest hit is written last.
    always_comb begin
        found = `FALSE;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int pos;
            pos = (int'(start) + i) % NUM_REQ;
            if (req[pos]) begin
                found = `TRUE;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Burst-holding round-robin / fixed-priority arbiter for the shared memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int RR_ENABLE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_ce_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ-1:0][`ADDR_BUS] req_addr_i,
    input  logic [NUM_REQ-1:0][3:0]       req_width_i,
    input  logic [NUM_REQ-1:0][`DATA_BUS] req_data_i,
    output logic [NUM_REQ-1:0][`DATA_BUS] req_data_o,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          mem_ce_o,
    output logic                          mem_we_o,
    output logic [`ADDR_BUS]              mem_addr_o,
    output logic [3:0]                    mem_width_o,
    output logic [`DATA_BUS]              mem_data_o,
    input  logic [`DATA_BUS]              mem_data_i,
    output logic                          busy_o
);

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_t          state_p0, state_nxt;
    logic [IDX_W-1:0]    owner_p0, owner_nxt;
    logic [IDX_W-1:0]    last_p0, last_nxt;
    logic [NUM_REQ-1:0]  gnt_p0, gnt_nxt;
    logic [IDX_W-1:0]    scan_start;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;

    // Fixed priority always scans from 0; round-robin starts just past the last owner.
    always_comb begin
        scan_start = '0;
        if (RR_ENABLE != 0 && last_p0 != IDX_W'(NUM_REQ - 1)) begin
            scan_start = last_p0 + IDX_W'(1);
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_ce_i),
        .start (scan_start),
        .found (win_found),
        .idx   (win_idx)
    );

    always_comb begin
        state_nxt = state_p0;
        owner_nxt = owner_p0;
        last_nxt  = last_p0;
        gnt_nxt   = gnt_p0;
        case (state_p0)
            ARB_IDLE: begin
                if (win_found) begin
                    gnt_nxt   = NUM_REQ'(1) << win_idx;
                    owner_nxt = win_idx;
                    last_nxt  = win_idx;
                    state_nxt = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                // Owner keeps the port for as long as its ce stays high.
                if (!req_ce_i[owner_p0]) begin
                    if (win_found) begin
                        gnt_nxt   = NUM_REQ'(1) << win_idx;
                        owner_nxt = win_idx;
                        last_nxt  = win_idx;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // ---- arbitration register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= ARB_IDLE;
            owner_p0 <= '0;
            last_p0  <= IDX_W'(NUM_REQ - 1);
            gnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            owner_p0 <= owner_nxt;
            last_p0  <= last_nxt;
            gnt_p0   <= gnt_nxt;
        end
    end

    assign gnt_o  = gnt_p0;
    assign busy_o = |gnt_p0;

    always_comb begin
        mem_ce_o    = `FALSE;
        mem_we_o    = `FALSE;
        mem_addr_o  = `ZERO_ADDR;
        mem_width_o = 4'd0;
        mem_data_o  = `ZERO_DATA;
        req_data_o  = '0;
        if (busy_o) begin
            mem_ce_o             = req_ce_i[owner_p0];
            mem_we_o             = req_we_i[owner_p0];
            mem_addr_o           = req_addr_i[owner_p0];
            mem_width_o          = req_width_i[owner_p0];
            mem_data_o           = req_data_i[owner_p0];
            req_data_o[owner_p0] = mem_data_i;
        end
    end

endmodule
